// File: rtl/fios_collect_pkg.sv
// Shared types for the FIOS result collector: default word width, FSM states, word type.
package fios_collect_pkg;

  localparam int DEFAULT_WORD_WIDTH = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  typedef logic [DEFAULT_WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/fios_word_sub.sv
// One word of the serial final subtraction: diff = a - b - borrow_in with borrow out.
module fios_word_sub #(
  parameter int WIDTH = fios_collect_pkg::DEFAULT_WORD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // One extra bit: the MSB of the widened difference is set exactly when a < b + borrow_in.
  logic [WIDTH:0] wide;

  assign wide       = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, borrow_in};
  assign diff       = wide[WIDTH-1:0];
  assign borrow_out = wide[WIDTH];

endmodule

// File: rtl/fios_res_collector.sv
// Captures FIOS chain result words, applies the final conditional subtraction and streams
// the reduced result out LSW first. Subtraction is compiled only with FIOS_FINAL_SUB_EN.
//
// state   | meaning
// IDLE    | waiting for start_i
// COLLECT | capturing result words from the last PE
// OUTPUT  | streaming the reduced words over valid/ready
module fios_res_collector
  import fios_collect_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int WORD_COUNT = 16,
  localparam int CNT_WIDTH = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  res_valid_i,
  input  logic [WORD_WIDTH-1:0] res_i,
  input  logic [WORD_WIDTH-1:0] p_i,
  input  logic                  res_carry_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WORD_WIDTH-1:0] out_word_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WORD_COUNT - 1);

  state_t                state;
  logic [CNT_WIDTH-1:0]  wr_cnt;
  logic [CNT_WIDTH-1:0]  rd_cnt;
  logic [CNT_WIDTH-1:0]  rd_nxt;
  logic                  capture;
  logic                  wr_last;
  logic                  rd_last;
  logic [WORD_WIDTH-1:0] word_first;
  logic [WORD_WIDTH-1:0] word_next;
  logic [WORD_WIDTH-1:0] t_buf [WORD_COUNT];

  assign capture = (state == COLLECT) && res_valid_i && !start_i;
  assign wr_last = (wr_cnt == LAST_IDX);
  assign rd_last = (rd_cnt == LAST_IDX);
  assign rd_nxt  = rd_cnt + CNT_WIDTH'(1);

`ifdef FIOS_FINAL_SUB_EN
  logic                  borrow;
  logic                  borrow_nxt;
  logic                  sel_d;
  logic [WORD_WIDTH-1:0] diff;
  logic [WORD_WIDTH-1:0] d_buf [WORD_COUNT];

  fios_word_sub #(
    .WIDTH(WORD_WIDTH)
  ) u_word_sub (
    .a          (res_i),
    .b          (p_i),
    .borrow_in  (borrow),
    .diff       (diff),
    .borrow_out (borrow_nxt)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      borrow <= 1'b0;
      sel_d  <= 1'b0;
    end else if (start_i) begin
      borrow <= 1'b0;
    end else if (capture) begin
      borrow <= borrow_nxt;
      // A set top carry means T exceeds any s-word modulus, so it overrides the borrow.
      if (wr_last) sel_d <= res_carry_i | ~borrow_nxt;
    end
  end

  always_ff @(posedge clock_i) begin
    if (capture) d_buf[wr_cnt] <= diff;
  end

  assign word_first = sel_d ? d_buf[0] : t_buf[0];
  assign word_next  = sel_d ? d_buf[rd_nxt] : t_buf[rd_nxt];
`else
  logic unused_inputs;

  assign unused_inputs = ^{p_i, res_carry_i};
  assign word_first    = t_buf[0];
  assign word_next     = t_buf[rd_nxt];
`endif

  // Buffer contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clock_i) begin
    if (capture) t_buf[wr_cnt] <= res_i;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_word_o  <= '0;
      busy_o      <= 1'b0;
    end else if (start_i) begin
      state       <= COLLECT;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      busy_o      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          busy_o <= 1'b0;
        end
        COLLECT: begin
          if (res_valid_i) begin
            if (wr_last) state <= OUTPUT;
            else         wr_cnt <= wr_cnt + CNT_WIDTH'(1);
          end
        end
        OUTPUT: begin
          // Entry cycle: the last word has just landed in the buffers, present word 0.
          if (!out_valid_o) begin
            out_valid_o <= 1'b1;
            out_word_o  <= word_first;
            out_last_o  <= (LAST_IDX == '0);
            rd_cnt      <= '0;
          end else if (out_ready_i) begin
            if (rd_last) begin
              state       <= IDLE;
              out_valid_o <= 1'b0;
              out_last_o  <= 1'b0;
              busy_o      <= 1'b0;
            end else begin
              rd_cnt     <= rd_nxt;
              out_word_o <= word_next;
              out_last_o <= (rd_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fios_res_collector.sv
// Randomized and directed bench for fios_res_collector against a big-integer reference model.
module tb_fios_res_collector;

  localparam int W  = 17;
  localparam int WC = 2;

  typedef logic [W-1:0] vec_t [WC];

  logic         clock_i = 1'b0;
  logic         reset_n_i;
  logic         start_i;
  logic         res_valid_i;
  logic [W-1:0] res_i;
  logic [W-1:0] p_i;
  logic         res_carry_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] out_word_o;
  logic         out_last_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  fios_res_collector #(
    .WORD_WIDTH(W),
    .WORD_COUNT(WC)
  ) dut (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .start_i     (start_i),
    .res_valid_i (res_valid_i),
    .res_i       (res_i),
    .p_i         (p_i),
    .res_carry_i (res_carry_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_word_o  (out_word_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference: whole-number T and p; reduce once if T >= p.
  function automatic void model(input vec_t t, input vec_t p, input logic c, output vec_t e);
    longint unsigned tv = 0;
    longint unsigned pv = 0;
    longint unsigned r;
    for (int i = 0; i < WC; i++) begin
      tv = tv + (longint'(t[i]) << (W * i));
      pv = pv + (longint'(p[i]) << (W * i));
    end
    tv = tv + (longint'(c) << (W * WC));
`ifdef FIOS_FINAL_SUB_EN
    r = (tv >= pv) ? tv - pv : tv;
`else
    r = tv;
`endif
    for (int i = 0; i < WC; i++) e[i] = W'(r >> (W * i));
  endfunction

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  task automatic send_words(input vec_t t, input vec_t p, input logic c);
    for (int i = 0; i < WC; i++) begin
      res_valid_i = 1'b1;
      res_i       = t[i];
      p_i         = p[i];
      res_carry_i = (i == WC - 1) ? c : 1'($urandom);
      @(negedge clock_i);
    end
    res_valid_i = 1'b0;
    res_i       = W'($urandom);
    p_i         = W'($urandom);
    res_carry_i = 1'($urandom);
  endtask

  // Entered at the first negedge after the last word was captured.
  task automatic check_output(input vec_t e, input int hold, input string name);
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s latency: out_valid_o=%0b one cycle after last word, want 0", name, out_valid_o);
    end
    @(negedge clock_i);
    for (int h = 0; h < hold; h++) begin
      res_valid_i = 1'b1;
      res_i       = W'($urandom);
      checks++;
      if ({out_valid_o, out_word_o} !== {1'b1, e[0]}) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%0b word=%0d, want valid=1 word=%0d", name, h, out_valid_o, out_word_o, e[0]);
      end
      @(negedge clock_i);
    end
    res_valid_i = 1'b0;
    for (int i = 0; i < WC; i++) begin
      checks++;
      if ({out_valid_o, out_word_o, out_last_o} !== {1'b1, e[i], i == WC - 1}) begin
        errors++;
        $display("FAIL %s word%0d: valid=%0b word=%0d last=%0b, want valid=1 word=%0d last=%0b",
                 name, i, out_valid_o, out_word_o, out_last_o, e[i], i == WC - 1);
      end
      out_ready_i = 1'b1;
      @(negedge clock_i);
    end
    out_ready_i = 1'b0;
    checks++;
    if ({out_valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL %s done: valid=%0b busy=%0b, want 0 0", name, out_valid_o, busy_o);
    end
  endtask

  task automatic run_txn(input vec_t t, input vec_t p, input logic c, input int hold, input string name);
    vec_t e;
    model(t, p, c, e);
    pulse_start();
    send_words(t, p, c);
    check_output(e, hold, name);
  endtask

  task automatic test_reset();
    reset_n_i   = 1'b0;
    start_i     = 1'b0;
    res_valid_i = 1'b0;
    res_i       = '0;
    p_i         = '0;
    res_carry_i = 1'b0;
    out_ready_i = 1'b0;
    repeat (2) @(negedge clock_i);
    reset_n_i = 1'b1;
    @(negedge clock_i);
    checks++;
    if ({out_valid_o, out_last_o, busy_o, out_word_o} !== {3'b000, W'(0)}) begin
      errors++;
      $display("FAIL reset: valid=%0b last=%0b busy=%0b word=%0d, want all 0",
               out_valid_o, out_last_o, busy_o, out_word_o);
    end
  endtask

  task automatic test_directed();
    vec_t t, p;
    t = '{7, 0};      p = '{5, 0}; run_txn(t, p, 1'b0, 0, "t7_p5");
    t = '{3, 0};      p = '{5, 0}; run_txn(t, p, 1'b0, 0, "t3_p5");
    t = '{5, 0};      p = '{5, 0}; run_txn(t, p, 1'b0, 0, "t5_p5");
    t = '{1, 0};      p = '{3, 1}; run_txn(t, p, 1'b1, 0, "carry");
    t = '{131071, 1}; p = '{0, 1}; run_txn(t, p, 1'b0, 0, "top_eq");
  endtask

  task automatic test_backpressure();
    vec_t t, p;
    t = '{7, 0}; p = '{5, 0};
    run_txn(t, p, 1'b0, 5, "backpressure");
  endtask

  task automatic test_abort();
    vec_t t, p, e;
    pulse_start();
    res_valid_i = 1'b1; res_i = W'(99); p_i = W'(1);
    @(negedge clock_i);
    // Restart with a simultaneous valid word that must be dropped.
    start_i = 1'b1; res_i = W'(12345);
    @(negedge clock_i);
    start_i = 1'b0; res_valid_i = 1'b0;
    t = '{7, 0}; p = '{5, 0};
    model(t, p, 1'b0, e);
    send_words(t, p, 1'b0);
    check_output(e, 0, "abort_collect");

    pulse_start();
    t = '{40000, 3}; p = '{1, 2};
    send_words(t, p, 1'b0);
    @(negedge clock_i);
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    checks++;
    if ({out_valid_o, busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL abort_output: valid=%0b busy=%0b, want 0 1", out_valid_o, busy_o);
    end
    t = '{7, 0}; p = '{5, 0};
    model(t, p, 1'b0, e);
    send_words(t, p, 1'b0);
    check_output(e, 1, "abort_output_new");
  endtask

  task automatic test_random();
    vec_t t, p;
    logic c;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < WC; i++) begin
        p[i] = W'($urandom);
        t[i] = ($urandom_range(0, 1) == 0) ? p[i] + W'($urandom_range(0, 2)) - W'(1) : W'($urandom);
      end
      c = ($urandom_range(0, 3) == 0);
      run_txn(t, p, c, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_async_reset();
    vec_t t, p;
    t = '{7, 0}; p = '{5, 0};
    pulse_start();
    send_words(t, p, 1'b0);
    @(negedge clock_i);
    checks++;
    if ({out_valid_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL async_pre: valid=%0b busy=%0b, want 1 1", out_valid_o, busy_o);
    end
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, busy_o, out_last_o, out_word_o} !== {3'b000, W'(0)}) begin
      errors++;
      $display("FAIL async_reset: valid=%0b busy=%0b last=%0b word=%0d, want all 0",
               out_valid_o, busy_o, out_last_o, out_word_o);
    end
    @(negedge clock_i);
    reset_n_i = 1'b1;
    @(negedge clock_i);
    run_txn(t, p, 1'b0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
